// File: rtl/sample_pack_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sample_pack_fifo
//  Purpose  : Single-clock width-converting FIFO. Accepts one DW-bit sample
//             per cycle and returns RATIO samples packed into one
//             DW*RATIO-bit word per read (oldest sample in lane 0).
//  Ports    : clk, resetn (async active-low), flush (sync clear)
//             wr_en/din          - sample write side
//             rd_en/dout/dout_valid - packed word read side (1-cycle latency)
//             full, almost_full, empty, level - occupancy status (samples)
//             overflow, underflow - sticky error flags
//  Revision : 1.0 - initial release
// ============================================================================
module sample_pack_fifo #(
  parameter int DW       = 12,
  parameter int RATIO    = 4,
  parameter int DEPTH    = 128,
  parameter int AF_LEVEL = 96
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DW-1:0]            din,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DW*RATIO-1:0]      dout,
  output logic                     dout_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW    = $clog2(DEPTH);   // sample pointer width
  localparam int LW    = $clog2(RATIO);   // lane-select width
  localparam int WORDS = DEPTH / RATIO;
  localparam int WAW   = AW - LW;         // word pointer width
  localparam int LVW   = AW + 1;          // level width (0..DEPTH)

  // Elaboration-time parameter sanity checks
  if (((DEPTH & (DEPTH - 1)) != 0) || ((DEPTH % RATIO) != 0)) begin : g_bad_depth
    $error("sample_pack_fifo: DEPTH must be a power of two and a multiple of RATIO");
  end
  if (((RATIO & (RATIO - 1)) != 0) || (RATIO < 1) || (DEPTH < 2 * RATIO)) begin : g_bad_ratio
    $error("sample_pack_fifo: RATIO must be a power of two and DEPTH >= 2*RATIO");
  end

  // State registers
  logic [AW-1:0]          wr_ptr_q,     wr_ptr_d;
  logic [WAW-1:0]         rd_ptr_q,     rd_ptr_d;
  logic [LVW-1:0]         level_q,      level_d;
  logic [DW*RATIO-1:0]    dout_q,       dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   overflow_q,   overflow_d;
  logic                   underflow_q,  underflow_d;

  logic                   wr_accept;
  logic                   rd_accept;
  logic [WAW-1:0]         wr_word;
  logic [RATIO-1:0]       wr_lane_sel;
  logic [RATIO-1:0][DW-1:0] rd_lanes;

  // Status flags are decoded from the registered level only, so there is
  // no combinational path from wr_en/rd_en to any flag.
  assign full        = (level_q == LVW'(DEPTH));
  assign almost_full = (level_q >= LVW'(AF_LEVEL));
  assign empty       = (level_q <  LVW'(RATIO));

  // Flush blocks both accepts so no memory write or pointer move happens.
  assign wr_accept = wr_en & ~full  & ~flush;
  assign rd_accept = rd_en & ~empty & ~flush;

  // Upper sample-pointer bits pick the word, lower bits pick the lane.
  assign wr_word = wr_ptr_q[AW-1:LW];

  if (RATIO == 1) begin : g_lane_sel_r1
    assign wr_lane_sel = 1'b1;
  end else begin : g_lane_sel_rn
    assign wr_lane_sel = RATIO'(1) << wr_ptr_q[LW-1:0];
  end

  // One narrow memory per lane; together they form the DEPTH/RATIO x
  // DW*RATIO dual-port array with per-lane write enables.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    logic [DW-1:0] lane_mem [WORDS];

    always_ff @(posedge clk) begin
      if (wr_accept && wr_lane_sel[k]) begin
        lane_mem[wr_word] <= din;
      end
    end

    assign rd_lanes[k] = lane_mem[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (flush) begin
      // dout deliberately keeps its last value.
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + WAW'(1);
        dout_d   = rd_lanes;
      end
      dout_valid_d = rd_accept;
      level_d      = level_q + LVW'(wr_accept) - (rd_accept ? LVW'(RATIO) : '0);
      if (wr_en && full) begin
        overflow_d = 1'b1;
      end
      if (rd_en && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_pack_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_pack_fifo
//  Purpose  : Self-checking bench for sample_pack_fifo. Two instances:
//             default (DW=12, RATIO=4, DEPTH=128) and DW=16, RATIO=2, DEPTH=8.
//             Expected read words are queued when a read is issued and
//             popped by per-instance monitors whenever dout_valid is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sample_pack_fifo;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  // instance 1 (defaults)
  logic        flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [11:0] din = '0;
  logic        full, almost_full, dout_valid, empty, overflow, underflow;
  logic [47:0] dout;
  logic [7:0]  level;

  // instance 2 (DW=16, RATIO=2)
  logic        flush2 = 1'b0, wr2 = 1'b0, rd2 = 1'b0;
  logic [15:0] din2 = '0;
  logic        full2, af2, dv2, empty2, ovf2, udf2;
  logic [31:0] dout2;
  logic [3:0]  level2;

  int total = 0;
  int bad   = 0;

  logic [11:0] mq[$];      // samples held by instance 1
  logic [47:0] eq[$];      // expected words, instance 1
  logic [31:0] eq2[$];     // expected words, instance 2
  logic [47:0] last_word = '0;

  always #5 clk = ~clk;

  sample_pack_fifo u_dut (
    .clk(clk), .resetn(resetn), .flush(flush), .wr_en(wr_en), .din(din),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .dout(dout),
    .dout_valid(dout_valid), .empty(empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  sample_pack_fifo #(.DW(16), .RATIO(2), .DEPTH(8), .AF_LEVEL(6)) u_dut2 (
    .clk(clk), .resetn(resetn), .flush(flush2), .wr_en(wr2), .din(din2),
    .full(full2), .almost_full(af2), .rd_en(rd2), .dout(dout2),
    .dout_valid(dv2), .empty(empty2), .level(level2),
    .overflow(ovf2), .underflow(udf2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: compare every presented word against the scoreboard.
  always @(negedge clk) begin
    if (resetn && dout_valid) begin
      if (eq.size() == 0) begin
        chk("dut1_unexpected_valid", 64'(dout_valid), 64'd0);
      end else begin
        chk("dut1_dout", 64'(dout), 64'(eq.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && dv2) begin
      if (eq2.size() == 0) begin
        chk("dut2_unexpected_valid", 64'(dv2), 64'd0);
      end else begin
        chk("dut2_dout", 64'(dout2), 64'(eq2.pop_front()));
      end
    end
  end

  // One clock of stimulus on instance 1; updates the sample model.
  task automatic step1(input bit w, input logic [11:0] d, input bit r, input bit f);
    int sz;
    logic [47:0] word;
    sz    = mq.size();
    wr_en = w;
    din   = d;
    rd_en = r;
    flush = f;
    if (f) begin
      mq.delete();
    end else begin
      if (r && sz >= 4) begin
        word = '0;
        for (int k = 0; k < 4; k++) word[k*12 +: 12] = mq.pop_front();
        eq.push_back(word);
        last_word = word;
      end
      if (w && sz < 128) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // reset state while still in reset
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_dvalid", 64'(dout_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_udf", 64'(underflow), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // 1: four samples, one packed read
    for (int i = 1; i <= 4; i++) step1(1'b1, 12'(i), 1'b0, 1'b0);
    chk("s1_level4", 64'(level), 64'd4);
    chk("s1_empty0", 64'(empty), 64'd0);
    step1(1'b0, 12'h0, 1'b1, 1'b0);
    chk("s1_dout", 64'(dout), 64'h004003002001);
    chk("s1_dvalid", 64'(dout_valid), 64'd1);
    chk("s1_level0", 64'(level), 64'd0);
    chk("s1_empty1", 64'(empty), 64'd1);

    // 2: fill to full, then overflow
    for (int i = 1; i <= 127; i++) begin
      step1(1'b1, 12'(i), 1'b0, 1'b0);
      chk("s2_af", 64'(almost_full), 64'(i >= 96));
    end
    chk("s2_full0", 64'(full), 64'd0);
    chk("s2_empty0", 64'(empty), 64'd0);
    step1(1'b1, 12'd128, 1'b0, 1'b0);
    chk("s2_full1", 64'(full), 64'd1);
    step1(1'b1, 12'd129, 1'b0, 1'b0);
    chk("s2_ovf", 64'(overflow), 64'd1);
    chk("s2_level", 64'(level), 64'd128);

    // 3: drain all 32 words (pointers wrap), then one read too many
    for (int i = 0; i < 32; i++) step1(1'b0, 12'h0, 1'b1, 1'b0);
    chk("s3_empty", 64'(empty), 64'd1);
    chk("s3_level", 64'(level), 64'd0);
    chk("s3_udf0", 64'(underflow), 64'd0);
    step1(1'b0, 12'h0, 1'b1, 1'b0);
    chk("s3_udf1", 64'(underflow), 64'd1);
    chk("s3_dout_hold", 64'(dout), 64'h08007F07E07D);
    chk("s3_dvalid0", 64'(dout_valid), 64'd0);

    // 4: read at level 3 rejected; simultaneous read+write at level 5
    step1(1'b0, 12'h0, 1'b0, 1'b1);
    chk("s4_udf_cleared", 64'(underflow), 64'd0);
    for (int i = 1; i <= 3; i++) step1(1'b1, 12'(12'h100 + i), 1'b0, 1'b0);
    step1(1'b0, 12'h0, 1'b1, 1'b0);
    chk("s4_udf", 64'(underflow), 64'd1);
    chk("s4_level3", 64'(level), 64'd3);
    step1(1'b1, 12'h104, 1'b0, 1'b0);
    step1(1'b1, 12'h105, 1'b0, 1'b0);
    step1(1'b1, 12'h106, 1'b1, 1'b0);
    chk("s4_level2", 64'(level), 64'd2);
    chk("s4_dout", 64'(dout), 64'h104103102101);

    // 5: level 60 with overflow, then flush with wr_en and rd_en
    step1(1'b0, 12'h0, 1'b0, 1'b1);
    for (int i = 0; i < 128; i++) step1(1'b1, 12'(12'h200 + i), 1'b0, 1'b0);
    step1(1'b1, 12'hFFF, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) step1(1'b0, 12'h0, 1'b1, 1'b0);
    chk("s5_level60", 64'(level), 64'd60);
    chk("s5_ovf1", 64'(overflow), 64'd1);
    step1(1'b1, 12'h555, 1'b1, 1'b1);
    chk("s5_level0", 64'(level), 64'd0);
    chk("s5_empty", 64'(empty), 64'd1);
    chk("s5_ovf0", 64'(overflow), 64'd0);
    chk("s5_dvalid0", 64'(dout_valid), 64'd0);
    chk("s5_dout_held", 64'(dout), 64'(last_word));
    for (int i = 1; i <= 4; i++) step1(1'b1, 12'(12'hA00 + i), 1'b0, 1'b0);
    step1(1'b0, 12'h0, 1'b1, 1'b0);
    chk("s5_addr0_word", 64'(dout), 64'hA04A03A02A01);

    // 6: asynchronous reset mid-burst
    step1(1'b1, 12'h0C1, 1'b0, 1'b0);
    step1(1'b1, 12'h0C2, 1'b0, 1'b0);
    wr_en = 1'b1;
    din   = 12'h0C3;
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("s6_level", 64'(level), 64'd0);
    chk("s6_dout", 64'(dout), 64'd0);
    chk("s6_empty", 64'(empty), 64'd1);
    chk("s6_dvalid", 64'(dout_valid), 64'd0);
    wr_en = 1'b0;
    mq.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // instance 2: two 16-bit samples packed into one 32-bit word
    chk("s6b_empty", 64'(empty2), 64'd1);
    wr2 = 1'b1; din2 = 16'hAAAA;
    @(posedge clk); #1;
    din2 = 16'hBBBB;
    @(posedge clk); #1;
    wr2 = 1'b0;
    chk("s6b_level2", 64'(level2), 64'd2);
    rd2 = 1'b1;
    eq2.push_back(32'hBBBBAAAA);
    @(posedge clk); #1;
    rd2 = 1'b0;
    chk("s6b_dout", 64'(dout2), 64'hBBBBAAAA);
    chk("s6b_level0", 64'(level2), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard1_drained", 64'(eq.size()), 64'd0);
    chk("scoreboard2_drained", 64'(eq2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
